sc_safety_monitor: RTL and testbench

- Producer end of the fault path: drives fault_flag and fault_code, which the charging FSM consumes.
- Watches grid_state, current_state, ml_predict_instability and the battery/charge handshake.
- Debounces each hazard, latches a prioritised 4-bit fault code and holds it until an operator clear plus a hold-off window completes.
- Repeated trips escalate to a lockout that only reset releases.

---
 rtl/sc_types_pkg.sv | 56 +++++
 rtl/sc_debounce_cnt.sv | 48 ++++
 rtl/sc_safety_monitor.sv | 157 +++++++++++++++
 tb/tb_sc_safety_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_types_pkg.sv
// ----------------------------------------------------------------------------
// sc_types_pkg
// Types shared by the charging controller and its safety monitor:
//   grid_state_t  - grid health classification
//   state_t       - charging FSM state (monitor only looks for ST_CHARGING)
//   fault_code_t  - 4-bit fault code reported on the fault path
//   mon_state_t   - safety monitor state
// prio_code() maps a set of simultaneous hazards to the single code reported.
// ----------------------------------------------------------------------------
package sc_types_pkg;

    typedef enum logic [1:0] {
        GRID_STABLE   = 2'd0,
        GRID_UNSTABLE = 2'd1,
        GRID_OUTAGE   = 2'd2
    } grid_state_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRECHARGE   = 3'd1,
        ST_CHARGING    = 3'd2,
        ST_DISCHARGING = 3'd3,
        ST_FAULT       = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        FC_NONE           = 4'h0,
        FC_GRID_OUTAGE    = 4'h1,
        FC_GRID_UNSTABLE  = 4'h2,
        FC_ML_PREDICT     = 4'h3,
        FC_CHARGE_NO_BATT = 4'h4,
        FC_LOCKOUT        = 4'hF
    } fault_code_t;

    typedef enum logic [1:0] {
        MON_OK      = 2'd0,
        MON_FAULT   = 2'd1,
        MON_HOLDOFF = 2'd2,
        MON_LOCKOUT = 2'd3
    } mon_state_t;

    // Priority: outage > missing battery > unstable grid > ML prediction.
    function automatic fault_code_t prio_code(input logic outage,
                                              input logic nobatt,
                                              input logic unstable,
                                              input logic ml);
        fault_code_t code;
        code = FC_NONE;
        if (outage)        code = FC_GRID_OUTAGE;
        else if (nobatt)   code = FC_CHARGE_NO_BATT;
        else if (unstable) code = FC_GRID_UNSTABLE;
        else if (ml)       code = FC_ML_PREDICT;
        return code;
    endfunction

endpackage

// File: rtl/sc_debounce_cnt.sv
// ----------------------------------------------------------------------------
// sc_debounce_cnt
// Saturating consecutive-cycle counter for one hazard condition.
//   clk, rst_n - clock, asynchronous active-low reset
//   cond       - raw condition, sampled every cycle
//   flush      - zero the counter on the next edge
//   hit        - condition is high for the THRESH-th consecutive cycle
// ----------------------------------------------------------------------------
module sc_debounce_cnt
    import sc_types_pkg::*;
#(
    parameter int unsigned THRESH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cond,
    input  logic flush,
    output logic hit
);

    localparam int unsigned W = (THRESH > 1) ? $clog2(THRESH) : 1;
    localparam logic [W-1:0] LAST = W'(THRESH - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // The counter holds the number of previous consecutive high cycles, so
    // hit is asserted combinationally during the THRESH-th high cycle and
    // the monitor can register the fault on the edge that samples it.
    assign hit = cond && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (flush || !cond) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sc_safety_monitor.sv
// ----------------------------------------------------------------------------
// sc_safety_monitor
// Debounces grid/predictor/battery hazards, latches a prioritised fault code,
// releases it after an operator clear plus a quiet hold-off window, and locks
// out after MAX_TRIPS trips until reset.
//   clk, rst_n              - clock, asynchronous active-low reset
//   grid_state              - grid classification
//   current_state           - charging FSM state
//   ml_predict_instability  - predictor warning
//   charge_enable           - FSM charge command
//   battery_connected       - battery presence
//   fault_clear             - single-cycle operator clear request
//   fault_flag              - fault active (registered)
//   fault_code              - latched fault code (registered)
//   fault_clear_ack         - one-cycle pulse: clear accepted
//   trip_count              - trips since reset, saturating at MAX_TRIPS
// ----------------------------------------------------------------------------
module sc_safety_monitor
    import sc_types_pkg::*;
#(
    parameter int unsigned OUTAGE_CYCLES   = 4,
    parameter int unsigned UNSTABLE_CYCLES = 16,
    parameter int unsigned ML_CYCLES       = 8,
    parameter int unsigned BATT_CYCLES     = 2,
    parameter int unsigned HOLDOFF_CYCLES  = 32,
    parameter int unsigned MAX_TRIPS       = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  grid_state_t                    grid_state,
    input  state_t                         current_state,
    input  logic                           ml_predict_instability,
    input  logic                           charge_enable,
    input  logic                           battery_connected,
    input  logic                           fault_clear,
    output logic                           fault_flag,
    output logic [3:0]                     fault_code,
    output logic                           fault_clear_ack,
    output logic [$clog2(MAX_TRIPS+1)-1:0] trip_count
);

    localparam int unsigned TW = $clog2(MAX_TRIPS + 1);
    localparam int unsigned HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [TW-1:0] TRIP_MAX  = TW'(MAX_TRIPS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    mon_state_t    state_q, state_d;
    fault_code_t   code_q, code_d;
    logic          flag_q, flag_d;
    logic          ack_q, ack_d;
    logic [TW-1:0] trips_q, trips_d, trips_inc;
    logic [HW-1:0] hold_q, hold_d;
    logic          flush;

    logic outage_raw, unstable_raw, ml_raw, nobatt_raw, any_raw;
    logic outage_hit, unstable_hit, ml_hit, nobatt_hit, any_hit;

    assign outage_raw   = (grid_state == GRID_OUTAGE);
    assign unstable_raw = (grid_state == GRID_UNSTABLE);
    assign ml_raw       = ml_predict_instability && (current_state == ST_CHARGING);
    assign nobatt_raw   = charge_enable && !battery_connected;
    assign any_raw      = outage_raw || unstable_raw || ml_raw || nobatt_raw;

    sc_debounce_cnt #(.THRESH(OUTAGE_CYCLES)) u_db_outage (
        .clk(clk), .rst_n(rst_n), .cond(outage_raw), .flush(flush), .hit(outage_hit)
    );
    sc_debounce_cnt #(.THRESH(UNSTABLE_CYCLES)) u_db_unstable (
        .clk(clk), .rst_n(rst_n), .cond(unstable_raw), .flush(flush), .hit(unstable_hit)
    );
    sc_debounce_cnt #(.THRESH(ML_CYCLES)) u_db_ml (
        .clk(clk), .rst_n(rst_n), .cond(ml_raw), .flush(flush), .hit(ml_hit)
    );
    sc_debounce_cnt #(.THRESH(BATT_CYCLES)) u_db_nobatt (
        .clk(clk), .rst_n(rst_n), .cond(nobatt_raw), .flush(flush), .hit(nobatt_hit)
    );

    assign any_hit   = outage_hit || unstable_hit || ml_hit || nobatt_hit;
    assign trips_inc = (trips_q == TRIP_MAX) ? trips_q : trips_q + 1'b1;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        trips_d = trips_q;
        hold_d  = hold_q;
        ack_d   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            MON_OK: begin
                code_d = FC_NONE;
                if (any_hit) begin
                    trips_d = trips_inc;
                    if (trips_inc == TRIP_MAX) begin
                        state_d = MON_LOCKOUT;
                        code_d  = FC_LOCKOUT;
                    end else begin
                        state_d = MON_FAULT;
                        code_d  = prio_code(outage_hit, nobatt_hit, unstable_hit, ml_hit);
                    end
                end
            end
            MON_FAULT: begin
                if (fault_clear && !any_raw) begin
                    state_d = MON_HOLDOFF;
                    hold_d  = '0;
                    ack_d   = 1'b1;
                    flush   = 1'b1;
                end
            end
            MON_HOLDOFF: begin
                if (any_raw) begin
                    // Any raw hazard aborts the release without debouncing.
                    state_d = MON_FAULT;
                    code_d  = prio_code(outage_raw, nobatt_raw, unstable_raw, ml_raw);
                end else if (hold_q == HOLD_LAST) begin
                    state_d = MON_OK;
                    code_d  = FC_NONE;
                    hold_d  = '0;
                    flush   = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            MON_LOCKOUT: begin
                code_d = FC_LOCKOUT;
            end
            default: begin
                state_d = MON_OK;
                code_d  = FC_NONE;
            end
        endcase
        flag_d = (state_d != MON_OK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MON_OK;
            code_q  <= FC_NONE;
            flag_q  <= 1'b0;
            ack_q   <= 1'b0;
            trips_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            flag_q  <= flag_d;
            ack_q   <= ack_d;
            trips_q <= trips_d;
            hold_q  <= hold_d;
        end
    end

    assign fault_flag      = flag_q;
    assign fault_code      = code_q;
    assign fault_clear_ack = ack_q;
    assign trip_count      = trips_q;

endmodule

// File: tb/tb_sc_safety_monitor.sv
module tb_sc_safety_monitor;
    import sc_types_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    grid_state_t grid = GRID_STABLE;
    state_t      cur = ST_IDLE;
    logic        ml = 1'b0;
    logic        ce = 1'b0;
    logic        bc = 1'b1;
    logic        clr = 1'b0;
    logic        flag;
    logic [3:0]  code;
    logic        ack;
    logic [1:0]  trips;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic       ef;
        logic [3:0] ec;
        logic       ea;
        logic [1:0] et;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    sc_safety_monitor #(
        .OUTAGE_CYCLES(4),
        .UNSTABLE_CYCLES(16),
        .ML_CYCLES(8),
        .BATT_CYCLES(2),
        .HOLDOFF_CYCLES(32),
        .MAX_TRIPS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .grid_state(grid),
        .current_state(cur),
        .ml_predict_instability(ml),
        .charge_enable(ce),
        .battery_connected(bc),
        .fault_clear(clr),
        .fault_flag(flag),
        .fault_code(code),
        .fault_clear_ack(ack),
        .trip_count(trips)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_out(input string nm, input logic ef, input logic [3:0] ec,
                             input logic ea, input logic [1:0] et);
        n_chk++;
        if (flag !== ef || code !== ec || ack !== ea || trips !== et) begin
            n_fail++;
            $display("FAIL %s @%0t: got flag=%0b code=%0h ack=%0b trips=%0d, required flag=%0b code=%0h ack=%0b trips=%0d",
                     nm, $time, flag, code, ack, trips, ef, ec, ea, et);
        end
    endtask

    // Monitor: compare outputs after each active edge against queued expectations.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check_out(mon_e.nm, mon_e.ef, mon_e.ec, mon_e.ea, mon_e.et);
        end
    end

    // Inputs are already set; queue the outputs expected after the next edge.
    task automatic step(input logic ef, input logic [3:0] ec, input logic ea,
                        input logic [1:0] et, input string nm);
        exp_t e;
        e.cyc = cyc + 1;
        e.ef = ef; e.ec = ec; e.ea = ea; e.et = et; e.nm = nm;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        step(1'b0, 4'h0, 1'b0, 2'd0, "reset");
        step(1'b0, 4'h0, 1'b0, 2'd0, "reset_hold");
        rst_n = 1'b1;

        // Outage held: trips on the 4th edge
        grid = GRID_OUTAGE;
        for (int i = 1; i <= 4; i++)
            step(i == 4, (i == 4) ? 4'h1 : 4'h0, 1'b0, (i == 4) ? 2'd1 : 2'd0, "outage_db");

        // Clear while outage still high is ignored
        clr = 1'b1;
        step(1'b1, 4'h1, 1'b0, 2'd1, "clr_while_high");
        clr = 1'b0;
        step(1'b1, 4'h1, 1'b0, 2'd1, "clr_while_high_after");

        // Drop condition, clear accepted, full hold-off
        grid = GRID_STABLE;
        step(1'b1, 4'h1, 1'b0, 2'd1, "dropped");
        clr = 1'b1;
        step(1'b1, 4'h1, 1'b1, 2'd1, "clr_ack");
        clr = 1'b0;
        for (int k = 1; k <= 32; k++)
            step(k < 32, (k < 32) ? 4'h1 : 4'h0, 1'b0, 2'd1, "holdoff1");

        // Unstable for 15 cycles: no trip
        grid = GRID_UNSTABLE;
        for (int i = 1; i <= 15; i++)
            step(1'b0, 4'h0, 1'b0, 2'd1, "unstable15");
        grid = GRID_STABLE;
        step(1'b0, 4'h0, 1'b0, 2'd1, "unstable_gap");
        grid = GRID_UNSTABLE;
        for (int i = 1; i <= 16; i++)
            step(i == 16, (i == 16) ? 4'h2 : 4'h0, 1'b0, (i == 16) ? 2'd2 : 2'd1, "unstable16");

        // Clear, then nobatt reasserted at hold-off cycle 10 re-latches code 4
        grid = GRID_STABLE;
        clr = 1'b1;
        step(1'b1, 4'h2, 1'b1, 2'd2, "clr_ack2");
        clr = 1'b0;
        for (int k = 1; k <= 9; k++)
            step(1'b1, 4'h2, 1'b0, 2'd2, "holdoff2");
        ce = 1'b1; bc = 1'b0;
        step(1'b1, 4'h4, 1'b0, 2'd2, "holdoff_abort");
        step(1'b1, 4'h4, 1'b0, 2'd2, "refault_hold");
        ce = 1'b0; bc = 1'b1;
        clr = 1'b1;
        step(1'b1, 4'h4, 1'b1, 2'd2, "clr_ack3");
        clr = 1'b0;
        for (int k = 1; k <= 32; k++)
            step(k < 32, (k < 32) ? 4'h4 : 4'h0, 1'b0, 2'd2, "holdoff3");

        // Third trip: lockout
        grid = GRID_OUTAGE;
        for (int i = 1; i <= 4; i++)
            step(i == 4, (i == 4) ? 4'hF : 4'h0, 1'b0, (i == 4) ? 2'd3 : 2'd2, "lockout");
        grid = GRID_STABLE;
        for (int i = 1; i <= 4; i++) begin
            clr = (i % 2 == 1);
            step(1'b1, 4'hF, 1'b0, 2'd3, "lockout_clr_ignored");
        end
        clr = 1'b0;

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1 check_out("async_rst", 1'b0, 4'h0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Outage and nobatt debounce on the same edge: outage wins
        grid = GRID_OUTAGE;
        step(1'b0, 4'h0, 1'b0, 2'd0, "prio_e1");
        step(1'b0, 4'h0, 1'b0, 2'd0, "prio_e2");
        ce = 1'b1; bc = 1'b0;
        step(1'b0, 4'h0, 1'b0, 2'd0, "prio_e3");
        step(1'b1, 4'h1, 1'b0, 2'd1, "prio_same_edge");
        grid = GRID_STABLE; ce = 1'b0; bc = 1'b1;
        step(1'b1, 4'h1, 1'b0, 2'd1, "prio_held");
        clr = 1'b1;
        step(1'b1, 4'h1, 1'b1, 2'd1, "clr_ack4");
        clr = 1'b0;
        for (int k = 1; k <= 32; k++)
            step(k < 32, (k < 32) ? 4'h1 : 4'h0, 1'b0, 2'd1, "holdoff4");

        // Clear in MON_OK produces no ack
        clr = 1'b1;
        step(1'b0, 4'h0, 1'b0, 2'd1, "clr_in_ok");
        clr = 1'b0;

        // ML warning only counts while charging
        ml = 1'b1; cur = ST_IDLE;
        for (int i = 1; i <= 10; i++)
            step(1'b0, 4'h0, 1'b0, 2'd1, "ml_not_charging");
        cur = ST_CHARGING;
        for (int i = 1; i <= 8; i++)
            step(i == 8, (i == 8) ? 4'h3 : 4'h0, 1'b0, (i == 8) ? 2'd2 : 2'd1, "ml_charging");
        ml = 1'b0;

        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
